trivium_stream_xor: RTL and testbench
=====================================

# trivium_stream_xor

Parametrised Trivium stream-cipher datapath: loads an 80-bit key and 80-bit IV, runs the 1152-round warm-up, then XORs DATA_W-bit plaintext words with keystream, UNROLL keystream bits per clock. Successor to the byte-serial UART cipher top: it adds wide words, a parallel round core, and valid/ready handshakes on both sides with output backpressure. It sits between the UART RX/TX byte path (or a wider bus adapter) and the link.

## Interface
- DATA_W, 8: plaintext/ciphertext word width; multiple of UNROLL.
- UNROLL, 1: Trivium rounds per clock; one of 1, 2, 4, 8, 16, 32, 64; must divide 1152 and DATA_W.
- clk_i  in  1  clock.
- n_rst_i  in  1  reset, synchronous, active-low.
- key_i  in  80  key; bit k goes to state s(k+1). Sampled on the init edge.
- iv_i  in  80  IV; bit k goes to state s(k+94). Sampled on the init edge.
- init_i  in  1  start (re)keying.
- in_valid_i / in_ready_o  in/out  1  plaintext handshake.
- dat_i  in  DATA_W  plaintext word.
- out_valid_o / out_ready_i  out/in  1  ciphertext handshake.
- dat_o  out  DATA_W  ciphertext word.
- keyed_o  out  1  warm-up complete; cipher usable.
- busy_o  out  1  high in WARMUP or PROC.

## Operation
- States:
  - IDLE: after reset.
  - WARMUP: advance UNROLL rounds per clock, no output.
  - READY: keyed, waiting for input.
  - PROC: N = DATA_W/UNROLL cycles, each consuming UNROLL keystream bits.
  - HOLD: out_valid_o high, waiting for out_ready_i.
- Init load: s1..s80 = key, s81..s93 = 0, s94..s173 = iv, s174..s285 = 0, s286..s288 = 1.
- Round:
  - t1 = s66^s93, t2 = s162^s177, t3 = s243^s288, z = t1^t2^t3.
  - t1 ^= s91&s92^s171, t2 ^= s175&s176^s264, t3 ^= s286&s287^s69.
  - Shift s1..s93 <= {t3, s1..s92}, s94..s177 <= {t1, s94..s176}, s178..s288 <= {t2, s178..s287}.
- Bit order: LSB first. The keystream bit produced in round j of a word (j = 0..DATA_W-1) XORs dat_i[j].
- Transitions:
  - IDLE, READY or HOLD with init_i=1: go to WARMUP; load the state; keyed_o <= 0; out_valid_o <= 0. The pending output word is discarded.
  - WARMUP: init_i is ignored. After WARMUP_CYC = 1152/UNROLL cycles, go to READY and set keyed_o <= 1.
  - READY with in_valid_i & in_ready_o: capture dat_i, go to PROC.
  - PROC: init_i is ignored. After N cycles, register dat_o, go to HOLD.
  - HOLD with out_ready_i: out_valid_o drops. If the input handshake also completes in that cycle, go to PROC; otherwise go to READY.
- in_ready_o = !init_i & (READY | (HOLD & out_ready_i)). init_i wins over data.
- Keystream state advances only in WARMUP and PROC. Stalls in READY and HOLD freeze it, so no keystream is skipped.
- Warm-up counter width: clog2(1152/UNROLL + 1). It wraps to 0 on leaving WARMUP.

## Timing
- Reset (n_rst_i low at an edge):
  - Outputs: dat_o = 0, out_valid_o = 0, in_ready_o = 0, keyed_o = 0, busy_o = 0.
  - State: FSM = IDLE, 288-bit state = 0, counters = 0.
  - Reset mid-operation abandons everything.
- init_i sampled high at edge E: WARMUP during cycles E+1 .. E+WARMUP_CYC. keyed_o and in_ready_o are high from cycle E+WARMUP_CYC+1.
- Input accepted at edge A: PROC during A+1 .. A+N; out_valid_o and dat_o are valid from A+N+1. Latency is N+1 cycles.
- Throughput with out_ready_i held high: one word per N+1 cycles. Back-to-back input is accepted in the HOLD-release cycle.
- dat_o and out_valid_o hold stable while out_valid_o & !out_ready_i.
- out_valid_o never asserts unless keyed_o is high.

## Configuration
- TRIVIUM_KS_TAP_EN defined: adds output port ks_o [DATA_W-1:0]. It carries the keystream word used for the current dat_o, and is valid and stable whenever out_valid_o is high. Reset value is 0.
- TRIVIUM_KS_TAP_EN undefined: the port and its register are absent. Cipher behaviour is identical.

## Structure
- Package trivium_pkg holds:
  - FSM state enum: IDLE, WARMUP, READY, PROC, HOLD.
  - Constants: TRIV_STATE_W = 288, TRIV_WARMUP_ROUNDS = 1152, KEY_W = IV_W = 80.
  - Tap index constants: 66, 69, 91, 92, 93, 162, 171, 175, 176, 177, 243, 264, 286, 287, 288.
- Sub-module trivium_round_unroll: combinational. Takes the 288-bit state and returns the next state after UNROLL rounds plus an UNROLL-bit keystream (bit 0 = first round).
- The top holds the FSM, counters, state register and data/output registers.

## Test plan
- DATA_W=8, UNROLL=8; init_i pulse, key=0, iv=0 -> keyed_o rises exactly 145 cycles after the init edge; busy_o high in cycles 1..144.
- Same configuration; encrypt 0xA5; re-init with the same key/iv; encrypt the resulting ciphertext -> 0xA5 returned. With TRIVIUM_KS_TAP_EN, ks_o == dat_o ^ 0xA5.
- DATA_W=32, UNROLL=4; 16 words compared against a bit-serial golden model (UNROLL=1 instance, same key/iv) -> identical dat_o sequence.
- out_ready_i low for 20 cycles after the first word -> dat_o stable and in_ready_o low throughout; the next word's ciphertext equals the no-stall golden value.
- init_i asserted during PROC -> ignored; asserted in HOLD -> out_valid_o drops next cycle and warm-up restarts.
- n_rst_i low for 1 cycle mid-WARMUP -> all outputs 0 next cycle, FSM in IDLE, and a fresh init reproduces the reference keystream.

Source files
------------

// File: rtl/trivium_pkg.sv
// Shared types, constants and helpers for the Trivium stream-XOR datapath.
// State bit s(i) of the cipher (1-based) lives at vector index i-1.
package trivium_pkg;

  localparam int TRIV_STATE_W       = 288;
  localparam int TRIV_WARMUP_ROUNDS = 1152;
  localparam int KEY_W              = 80;
  localparam int IV_W               = 80;

  localparam int TAP_66  = 66;
  localparam int TAP_69  = 69;
  localparam int TAP_91  = 91;
  localparam int TAP_92  = 92;
  localparam int TAP_93  = 93;
  localparam int TAP_162 = 162;
  localparam int TAP_171 = 171;
  localparam int TAP_175 = 175;
  localparam int TAP_176 = 176;
  localparam int TAP_177 = 177;
  localparam int TAP_243 = 243;
  localparam int TAP_264 = 264;
  localparam int TAP_286 = 286;
  localparam int TAP_287 = 287;
  localparam int TAP_288 = 288;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    READY  = 3'd2,
    PROC   = 3'd3,
    HOLD   = 3'd4
  } triv_fsm_e;

  function automatic logic triv_bit(input logic [TRIV_STATE_W-1:0] s, input int idx);
    return s[idx-1];
  endfunction

  function automatic logic [TRIV_STATE_W-1:0] triv_load(input logic [KEY_W-1:0] key,
                                                        input logic [IV_W-1:0]  iv);
    logic [TRIV_STATE_W-1:0] s;
    s               = '0;
    s[KEY_W-1:0]    = key;
    s[93 +: IV_W]   = iv;
    s[287:285]      = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_round_unroll.sv
// Combinational Trivium core: UNROLL rounds per call, keystream bit 0 from
// the first round.
module trivium_round_unroll
  import trivium_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic [TRIV_STATE_W-1:0] state_i,
  output logic [TRIV_STATE_W-1:0] state_o,
  output logic [UNROLL-1:0]       ks_o
);

  always_comb begin
    logic [TRIV_STATE_W-1:0] s;
    logic t1, t2, t3;
    // NOTE: blocking assignments here are deliberate; each round must see the
    // state produced by the previous one within the same evaluation.
    s    = state_i;
    t1   = 1'b0;
    t2   = 1'b0;
    t3   = 1'b0;
    ks_o = '0;
    for (int r = 0; r < UNROLL; r++) begin
      t1 = triv_bit(s, TAP_66)  ^ triv_bit(s, TAP_93);
      t2 = triv_bit(s, TAP_162) ^ triv_bit(s, TAP_177);
      t3 = triv_bit(s, TAP_243) ^ triv_bit(s, TAP_288);
      ks_o[r] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (triv_bit(s, TAP_91)  & triv_bit(s, TAP_92))  ^ triv_bit(s, TAP_171);
      t2 = t2 ^ (triv_bit(s, TAP_175) & triv_bit(s, TAP_176)) ^ triv_bit(s, TAP_264);
      t3 = t3 ^ (triv_bit(s, TAP_286) & triv_bit(s, TAP_287)) ^ triv_bit(s, TAP_69);
      // Three registers shift up by one; each new head bit enters at s1, s94, s178.
      s = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    end
    state_o = s;
  end

endmodule

// File: rtl/trivium_stream_xor.sv
// Trivium stream-XOR top: keying/warm-up FSM, keystream state and word datapath.
// Optional keystream tap port ks_o when TRIVIUM_KS_TAP_EN is defined.
module trivium_stream_xor
  import trivium_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int UNROLL = 1
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic [IV_W-1:0]   iv_i,
  input  logic              init_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] dat_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] dat_o,
`ifdef TRIVIUM_KS_TAP_EN
  output logic [DATA_W-1:0] ks_o,
`endif
  output logic              keyed_o,
  output logic              busy_o
);

  localparam int N          = DATA_W / UNROLL;
  localparam int WARMUP_CYC = TRIV_WARMUP_ROUNDS / UNROLL;
  localparam int CNT_W      = $clog2(WARMUP_CYC + 1);
  localparam int BEAT_W     = (N > 1) ? $clog2(N) : 1;

  triv_fsm_e               fsm_q, fsm_d;
  logic [TRIV_STATE_W-1:0] st_q, st_d, st_nxt;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [DATA_W-1:0]       pt_q, pt_d;
  logic [DATA_W-1:0]       ks_acc_q, ks_acc_d, ks_shift;
  logic [DATA_W-1:0]       dat_q, dat_d;
  logic [UNROLL-1:0]       ks_rnd;
`ifdef TRIVIUM_KS_TAP_EN
  logic [DATA_W-1:0]       ks_out_q, ks_out_d;
`endif

  trivium_round_unroll #(.UNROLL(UNROLL)) u_round (
    .state_i (st_q),
    .state_o (st_nxt),
    .ks_o    (ks_rnd)
  );

  // New keystream enters at the top so the first round ends up at bit 0.
  assign ks_shift = DATA_W'({ks_rnd, ks_acc_q} >> UNROLL);

  always_comb begin
    // NOTE: every _d defaults to its _q so no path through the case infers a latch.
    fsm_d    = fsm_q;
    st_d     = st_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    pt_d     = pt_q;
    ks_acc_d = ks_acc_q;
    dat_d    = dat_q;
`ifdef TRIVIUM_KS_TAP_EN
    ks_out_d = ks_out_q;
`endif
    unique case (fsm_q)
      IDLE, READY, HOLD: begin
        if (init_i) begin
          fsm_d = WARMUP;
          st_d  = triv_load(key_i, iv_i);
          cnt_d = '0;
        end else if (fsm_q == READY && in_valid_i) begin
          fsm_d  = PROC;
          pt_d   = dat_i;
          beat_d = '0;
        end else if (fsm_q == HOLD && out_ready_i) begin
          fsm_d  = in_valid_i ? PROC : READY;
          pt_d   = in_valid_i ? dat_i : pt_q;
          beat_d = '0;
        end
      end
      WARMUP: begin
        st_d = st_nxt;
        if (cnt_q == CNT_W'(WARMUP_CYC - 1)) begin
          fsm_d = READY;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PROC: begin
        st_d     = st_nxt;
        ks_acc_d = ks_shift;
        if (beat_q == BEAT_W'(N - 1)) begin
          fsm_d  = HOLD;
          dat_d  = pt_q ^ ks_shift;
          beat_d = '0;
`ifdef TRIVIUM_KS_TAP_EN
          ks_out_d = ks_shift;
`endif
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (!n_rst_i) begin
      fsm_q    <= IDLE;
      st_q     <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      pt_q     <= '0;
      ks_acc_q <= '0;
      dat_q    <= '0;
`ifdef TRIVIUM_KS_TAP_EN
      ks_out_q <= '0;
`endif
    end else begin
      fsm_q    <= fsm_d;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      pt_q     <= pt_d;
      ks_acc_q <= ks_acc_d;
      dat_q    <= dat_d;
`ifdef TRIVIUM_KS_TAP_EN
      ks_out_q <= ks_out_d;
`endif
    end
  end

  assign dat_o       = dat_q;
  assign out_valid_o = (fsm_q == HOLD);
  assign keyed_o     = (fsm_q == READY) || (fsm_q == PROC) || (fsm_q == HOLD);
  assign busy_o      = (fsm_q == WARMUP) || (fsm_q == PROC);
  assign in_ready_o  = !init_i && ((fsm_q == READY) || (fsm_q == HOLD && out_ready_i));
`ifdef TRIVIUM_KS_TAP_EN
  assign ks_o        = ks_out_q;
`endif

endmodule

// File: tb/tb_trivium_stream_xor.sv
// Self-checking bench: two instances (8b/unroll 8, 32b/unroll 4) checked
// against a bit-serial Trivium model through expected-value queues.
module tb_trivium_stream_xor;

  logic clk;
  logic n_rst;

  logic [79:0] a_key, a_iv;
  logic        a_init, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_keyed, a_busy;
  logic [7:0]  a_dat_i, a_dat_o;
  logic [79:0] b_key, b_iv;
  logic        b_init, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_keyed, b_busy;
  logic [31:0] b_dat_i, b_dat_o;
`ifdef TRIVIUM_KS_TAP_EN
  logic [7:0]  a_ks;
  logic [31:0] b_ks;
`endif

  int checks = 0;
  int errors = 0;

  logic [287:0] ma, mb;
  logic [7:0]   exp_a[$];
  logic [31:0]  exp_b[$];
  logic [7:0]   ref_ct;

  trivium_stream_xor #(.DATA_W(8), .UNROLL(8)) u_dut_a (
    .clk_i(clk), .n_rst_i(n_rst), .key_i(a_key), .iv_i(a_iv), .init_i(a_init),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .dat_i(a_dat_i),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .dat_o(a_dat_o),
`ifdef TRIVIUM_KS_TAP_EN
    .ks_o(a_ks),
`endif
    .keyed_o(a_keyed), .busy_o(a_busy)
  );

  trivium_stream_xor #(.DATA_W(32), .UNROLL(4)) u_dut_b (
    .clk_i(clk), .n_rst_i(n_rst), .key_i(b_key), .iv_i(b_iv), .init_i(b_init),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .dat_i(b_dat_i),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .dat_o(b_dat_o),
`ifdef TRIVIUM_KS_TAP_EN
    .ks_o(b_ks),
`endif
    .keyed_o(b_keyed), .busy_o(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- bit-serial reference model ----------------
  function automatic logic [287:0] m_load(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] s;
    s = '0;
    for (int i = 0; i < 80; i++) begin
      s[i]      = k[i];
      s[93 + i] = v[i];
    end
    s[285] = 1'b1; s[286] = 1'b1; s[287] = 1'b1;
    return s;
  endfunction

  task automatic m_step(inout logic [287:0] s, output logic z);
    logic t1, t2, t3;
    t1 = s[65]  ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90]  & s[91])  ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    s  = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endtask

  task automatic m_word(inout logic [287:0] s, input int nbits, output logic [31:0] ks);
    logic z;
    ks = '0;
    for (int i = 0; i < nbits; i++) begin
      m_step(s, z);
      ks[i] = z;
    end
  endtask

  task automatic m_keyed(output logic [287:0] s, input logic [79:0] k, input logic [79:0] v);
    logic z;
    s = m_load(k, v);
    repeat (1152) m_step(s, z);
  endtask

  // ---------------- instance A helpers (8b / unroll 8) ----------------
  task automatic a_start_init(input logic [79:0] k, input logic [79:0] v);
    @(negedge clk);
    a_key = k; a_iv = v; a_init = 1'b1;
    @(negedge clk);
    a_init = 1'b0;
    m_keyed(ma, k, v);
  endtask

  // Entered in cycle E+1 of an init edge E; checks busy/keyed over warm-up.
  task automatic a_wait_keyed();
    for (int c = 1; c <= 145; c++) begin
      #1;
      checks++;
      if (a_busy !== logic'(c <= 144)) begin
        errors++; $display("FAIL a_busy cycle %0d got %b", c, a_busy);
      end
      checks++;
      if (a_keyed !== logic'(c == 145)) begin
        errors++; $display("FAIL a_keyed cycle %0d got %b", c, a_keyed);
      end
      if (c < 145) @(negedge clk);
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL a_in_ready_after_warmup got %b exp 1", a_in_ready);
    end
  endtask

  task automatic a_xfer(input logic [7:0] pt, output logic [7:0] ct);
    logic [31:0] ks;
    logic [7:0]  exp;
    int          lat;
    ct = '0;
    a_out_ready = 1'b1; a_dat_i = pt; a_in_valid = 1'b1;
    #1;
    for (int c = 0; c < 50 && !a_in_ready; c++) begin
      @(negedge clk); #1;
    end
    if (!a_in_ready) begin
      checks++; errors++; a_in_valid = 1'b0;
      $display("FAIL a_accept_timeout got in_ready 0 exp 1");
      return;
    end
    m_word(ma, 8, ks);
    exp_a.push_back(pt ^ ks[7:0]);
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 1;
    #1;
    while (!a_out_valid && lat < 50) begin
      @(negedge clk); #1; lat++;
    end
    if (!a_out_valid) begin
      checks++; errors++; void'(exp_a.pop_front());
      $display("FAIL a_output_timeout got out_valid 0 exp 1");
      return;
    end
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL a_latency got %0d exp 2", lat);
    end
    exp = exp_a.pop_front();
    checks++;
    if (a_dat_o !== exp) begin
      errors++; $display("FAIL a_dat_o got %02h exp %02h", a_dat_o, exp);
    end
`ifdef TRIVIUM_KS_TAP_EN
    checks++;
    if (a_ks !== (a_dat_o ^ pt)) begin
      errors++; $display("FAIL a_ks_o got %02h exp %02h", a_ks, a_dat_o ^ pt);
    end
`endif
    ct = a_dat_o;
    @(negedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL a_out_valid_release got %b exp 0", a_out_valid);
    end
  endtask

  // ---------------- instance B helpers (32b / unroll 4) ----------------
  task automatic b_start_init(input logic [79:0] k, input logic [79:0] v);
    int cnt;
    @(negedge clk);
    b_key = k; b_iv = v; b_init = 1'b1;
    @(negedge clk);
    b_init = 1'b0;
    m_keyed(mb, k, v);
    cnt = 1;
    #1;
    while (!b_keyed && cnt < 400) begin
      @(negedge clk); #1; cnt++;
    end
    checks++;
    if (cnt != 289) begin
      errors++; $display("FAIL b_warmup_cycles got %0d exp 289", cnt);
    end
  endtask

  task automatic b_stream(input int nwords, input int stall_len);
    int          sent, recvd, stall_cnt, last_cyc;
    bit          seen, held_v;
    logic [31:0] held, pt_cur, ks, exp;
    sent = 0; recvd = 0; stall_cnt = 0; last_cyc = -1;
    seen = 1'b0; held_v = 1'b0; held = '0;
    pt_cur = $urandom;
    for (int cyc = 0; cyc < 3000 && recvd < nwords; cyc++) begin
      if (b_out_valid) seen = 1'b1;
      b_out_ready = 1'b1;
      if (seen && stall_cnt < stall_len) begin
        b_out_ready = 1'b0; stall_cnt++;
      end
      b_in_valid = (sent < nwords);
      b_dat_i    = pt_cur;
      #1;
      if (b_out_valid && !b_out_ready) begin
        checks++;
        if (b_in_ready !== 1'b0) begin
          errors++; $display("FAIL b_in_ready_stall got %b exp 0", b_in_ready);
        end
        if (held_v) begin
          checks++;
          if (b_dat_o !== held) begin
            errors++; $display("FAIL b_dat_o_stable got %08h exp %08h", b_dat_o, held);
          end
        end
        held_v = 1'b1; held = b_dat_o;
      end else begin
        held_v = 1'b0;
      end
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++; $display("FAIL b_unexpected_output got %08h", b_dat_o);
        end else begin
          exp = exp_b.pop_front();
          if (b_dat_o !== exp) begin
            errors++; $display("FAIL b_dat_o word %0d got %08h exp %08h", recvd, b_dat_o, exp);
          end
        end
`ifdef TRIVIUM_KS_TAP_EN
        checks++;
        if (b_ks !== (b_dat_o ^ exp)) begin
          errors++; $display("FAIL b_ks_o got %08h", b_ks);
        end
`endif
        if (stall_len == 0 && last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 9) begin
            errors++; $display("FAIL b_throughput got %0d exp 9", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        recvd++;
      end
      if (b_in_valid && b_in_ready) begin
        m_word(mb, 32, ks);
        exp_b.push_back(pt_cur ^ ks);
        sent++;
        pt_cur = $urandom;
      end
      @(negedge clk);
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    if (recvd < nwords) begin
      checks++; errors++;
      $display("FAIL b_stream_timeout got %0d words exp %0d", recvd, nwords);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({a_dat_o, a_out_valid, a_in_ready, a_keyed, a_busy} !== 12'h0) begin
      errors++; $display("FAIL reset_a got %03h exp 000", {a_dat_o, a_out_valid, a_in_ready, a_keyed, a_busy});
    end
    checks++;
    if ({b_dat_o, b_out_valid, b_in_ready, b_keyed, b_busy} !== 36'h0) begin
      errors++; $display("FAIL reset_b got %09h exp 0", {b_dat_o, b_out_valid, b_in_ready, b_keyed, b_busy});
    end
    n_rst = 1'b1;
  endtask

  task automatic test_warmup_timing();
    a_start_init(80'h0, 80'h0);
    a_wait_keyed();
  endtask

  task automatic test_roundtrip();
    logic [7:0] ct, ct2;
    a_xfer(8'hA5, ct);
    ref_ct = ct;
    a_start_init(80'h0, 80'h0);
    a_wait_keyed();
    a_xfer(ct, ct2);
    checks++;
    if (ct2 !== 8'hA5) begin
      errors++; $display("FAIL roundtrip got %02h exp a5", ct2);
    end
  endtask

  task automatic test_golden_32();
    b_start_init({$urandom, $urandom, 16'h5EED}, {$urandom, $urandom, 16'hC0DE});
    b_stream(16, 0);
  endtask

  task automatic test_backpressure();
    b_stream(4, 20);
  endtask

  task automatic test_init_in_proc_and_hold();
    logic [31:0] ks;
    logic [7:0]  exp, ct;
    @(negedge clk);
    a_out_ready = 1'b0; a_dat_i = 8'h3C; a_in_valid = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL ip_ready got %b exp 1", a_in_ready);
    end
    m_word(ma, 8, ks);
    exp = 8'h3C ^ ks[7:0];
    @(negedge clk);
    a_in_valid = 1'b0;
    a_key = 80'hFEDC_BA98_7654_3210_0F1E; a_iv = 80'h0123_4567_89AB_CDEF_F0E1;
    a_init = 1'b1;
    #1;
    checks++;
    if ({a_busy, a_out_valid} !== 2'b10) begin
      errors++; $display("FAIL ip_proc busy/valid got %b%b exp 10", a_busy, a_out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b10) begin
      errors++; $display("FAIL ip_hold valid/ready got %b%b exp 10", a_out_valid, a_in_ready);
    end
    checks++;
    if (a_dat_o !== exp) begin
      errors++; $display("FAIL ip_hold_dat got %02h exp %02h", a_dat_o, exp);
    end
    @(negedge clk);
    a_init = 1'b0;
    #1;
    checks++;
    if ({a_out_valid, a_keyed, a_busy} !== 3'b001) begin
      errors++; $display("FAIL ip_rewarm got %b%b%b exp 001", a_out_valid, a_keyed, a_busy);
    end
    m_keyed(ma, a_key, a_iv);
    a_wait_keyed();
    a_xfer(8'h5A, ct);
  endtask

  task automatic test_reset_mid_warmup();
    logic [7:0] ct;
    a_start_init(80'h1357_9BDF_2468_ACE0_1111, 80'h2222_3333_4444_5555_6666);
    repeat (50) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({a_dat_o, a_out_valid, a_in_ready, a_keyed, a_busy} !== 12'h0) begin
      errors++; $display("FAIL midrst_outputs got %03h exp 000", {a_dat_o, a_out_valid, a_in_ready, a_keyed, a_busy});
    end
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({a_in_ready, a_keyed, a_busy} !== 3'b000) begin
      errors++; $display("FAIL midrst_idle got %b%b%b exp 000", a_in_ready, a_keyed, a_busy);
    end
    a_start_init(80'h0, 80'h0);
    a_wait_keyed();
    a_xfer(8'hA5, ct);
    checks++;
    if (ct !== ref_ct) begin
      errors++; $display("FAIL midrst_reference got %02h exp %02h", ct, ref_ct);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    a_key = '0; a_iv = '0; a_init = 1'b0; a_in_valid = 1'b0; a_dat_i = '0; a_out_ready = 1'b1;
    b_key = '0; b_iv = '0; b_init = 1'b0; b_in_valid = 1'b0; b_dat_i = '0; b_out_ready = 1'b1;
    test_reset();
    test_warmup_timing();
    test_roundtrip();
    test_golden_32();
    test_backpressure();
    test_init_in_proc_and_hold();
    test_reset_mid_warmup();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
